// File: rtl/uart_tx_serializer.sv
// UART TX serializer: pops bytes from the TX FIFO and sends start/data/[parity]/stop frames on txd.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN (adds break_req).
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_BITS-1:0] fifo_data,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_req,
`endif
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP,
        BRK,
        BRK_REC
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_BITS-1:0] shift_reg;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] timer_reg;
    logic [IDX_W-1:0]     bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic                 par_en_reg;
    logic                 par_bit_reg;
    logic                 two_stop_reg;
    logic                 bit_end;
    logic                 brk;

`ifdef UART_TX_BREAK_EN
    assign brk = break_req;
`else
    assign brk = 1'b0;
`endif

    assign bit_end = (timer_reg == '0);
    assign busy    = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fifo_rd_en = 1'b0;
        tx_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (brk) begin
                    state_next = BRK;
                end else if (enable && !fifo_empty && !rst) begin
                    fifo_rd_en = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH:  state_next = START;
            START:  if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && bit_cnt_reg == LAST_IDX) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_next = STOP;
            STOP: begin
                // stop_cnt_reg marks the second stop bit when two stop bits are latched
                if (bit_end && (!two_stop_reg || stop_cnt_reg)) begin
                    tx_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            BRK:     if (!brk) state_next = BRK_REC;
            BRK_REC: if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd          <= 1'b1;
            shift_reg    <= '0;
            div_reg      <= '0;
            timer_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            par_en_reg   <= 1'b0;
            par_bit_reg  <= 1'b0;
            two_stop_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    txd <= !brk;
                end
                FETCH: begin
                    // Whole frame configuration is frozen here
                    shift_reg    <= fifo_data;
                    div_reg      <= baud_div;
                    timer_reg    <= baud_div;
                    par_en_reg   <= parity_en;
                    par_bit_reg  <= (^fifo_data) ^ parity_odd;
                    two_stop_reg <= two_stop;
                    bit_cnt_reg  <= '0;
                    stop_cnt_reg <= 1'b0;
                    txd          <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        txd       <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                        timer_reg <= div_reg;
                    end else begin
                        timer_reg <= timer_reg - DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer_reg <= div_reg;
                        if (bit_cnt_reg == LAST_IDX) begin
                            txd <= par_en_reg ? par_bit_reg : 1'b1;
                        end else begin
                            txd         <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[DATA_BITS-1:1]};
                            bit_cnt_reg <= bit_cnt_reg + IDX_W'(1);
                        end
                    end else begin
                        timer_reg <= timer_reg - DIV_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        txd       <= 1'b1;
                        timer_reg <= div_reg;
                    end else begin
                        timer_reg <= timer_reg - DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer_reg    <= div_reg;
                        stop_cnt_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - DIV_WIDTH'(1);
                    end
                end
                BRK: begin
                    // Release of break is followed by one full idle-high bit time
                    txd <= !brk;
                    if (!brk) begin
                        timer_reg <= baud_div;
                    end
                end
                BRK_REC: begin
                    if (!bit_end) begin
                        timer_reg <= timer_reg - DIV_WIDTH'(1);
                    end
                end
                default: begin
                    txd <= 1'b1;
                end
            endcase
        end
    end

endmodule
